// File: rtl/loba2_seq_mult_if.sv
// ----------------------------------------------------------------------------
// loba2_seq_mult_if
//   Handshake bundle for the sequential LOBA2 multiplier.
//   a, b       : 16-bit unsigned operands, sampled on the input handshake
//   in_valid   : operands valid                (master -> slave)
//   in_ready   : multiplier can take operands  (slave  -> master)
//   p          : 32-bit approximate product    (slave  -> master)
//   out_valid  : p valid                       (slave  -> master)
//   out_ready  : consumer takes p              (master -> slave)
//   busy       : multiplier not idle           (slave  -> master)
// ----------------------------------------------------------------------------
interface loba2_seq_mult_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] p;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, p, out_valid, busy
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, p, out_valid, busy
    );
endinterface

// File: rtl/loba2_seq_mult.sv
// ----------------------------------------------------------------------------
// loba2_seq_mult
//   Sequential LOBA2 approximate multiplier, 16-bit unsigned operands split
//   into 4-bit leading segments. One 4x4 multiplier and one accumulator adder
//   are shared across the HH, HL and LH terms; the FSM picks the term.
//   Result is bit-identical to the combinational LOBA2 16/4 multiplier.
//
// Ports
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : loba2_seq_mult_if.slave (operand / result handshakes, busy)
// ----------------------------------------------------------------------------
module loba2_seq_mult (
    input  logic              clk_i,
    input  logic              rst_i,
    loba2_seq_mult_if.slave   bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SPLIT = 3'd1;
    localparam logic [2:0] ST_HH    = 3'd2;
    localparam logic [2:0] ST_HL    = 3'd3;
    localparam logic [2:0] ST_LH    = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [15:0]      a_q, b_q;
    logic [31:0]      acc_q, acc_d;

    // Index 0 holds operand A, index 1 holds operand B.
    logic [1:0][15:0] op;
    logic [1:0][3:0]  xh_q, xl_q, kh_q, kl_q;
    logic [1:0][3:0]  xh_d, xl_d, kh_d, kl_d;

    logic [3:0]       mul_x, mul_y, k_x, k_y;
    logic [7:0]       prod;
    logic [4:0]       shamt;
    logic [31:0]      term;
    logic [31:0]      acc_sum;
    logic             accept;

    assign op = {b_q, a_q};

    // Highest set bit; 0 for a zero input (the clamp to 3 hides that case).
    function automatic logic [3:0] msb_idx(input logic [15:0] x);
        msb_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) msb_idx = 4'(i);
        end
    endfunction

    // Leading-one segmentation of both operands, evaluated from the
    // registered operands while the FSM sits in SPLIT.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_split
            logic [3:0]  msb_x, sh_x, msb_r, sh_r;
            logic [15:0] rem;

            assign msb_x    = msb_idx(op[gi]);
            assign kh_d[gi] = (msb_x < 4'd3) ? 4'd3 : msb_x;
            assign sh_x     = kh_d[gi] - 4'd3;
            assign xh_d[gi] = 4'(op[gi] >> sh_x);
            // Remainder below the high segment.
            assign rem      = op[gi] - ({12'd0, xh_d[gi]} << sh_x);
            assign msb_r    = msb_idx(rem);
            assign kl_d[gi] = (msb_r < 4'd3) ? 4'd3 : msb_r;
            assign sh_r     = kl_d[gi] - 4'd3;
            assign xl_d[gi] = (rem == 16'd0) ? 4'd0 : 4'(rem >> sh_r);
        end
    endgenerate

    // Shared multiplier operand select: HH by default, HL swaps in B's low
    // segment, LH swaps in A's low segment.
    always_comb begin
        mul_x = xh_q[0];
        mul_y = xh_q[1];
        k_x   = kh_q[0];
        k_y   = kh_q[1];
        case (state_q)
            ST_HL: begin
                mul_y = xl_q[1];
                k_y   = kl_q[1];
            end
            ST_LH: begin
                mul_x = xl_q[0];
                k_x   = kl_q[0];
            end
            default: ;
        endcase
    end

    assign prod    = {4'd0, mul_x} * {4'd0, mul_y};
    // Each k is at least 3, so the shift never goes negative (max 24).
    assign shamt   = {1'b0, k_x} + {1'b0, k_y} - 5'd6;
    assign term    = {24'd0, prod} << shamt;
    assign acc_sum = acc_q + term;

    assign accept  = bus.in_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SPLIT;
                    acc_d   = 32'd0;
                end
            end
            ST_SPLIT: begin
                // A zero operand skips the multiply phases; acc is already 0.
                if (a_q == 16'd0 || b_q == 16'd0) state_d = ST_DONE;
                else                              state_d = ST_HH;
            end
            ST_HH: begin
                acc_d   = acc_sum;
                state_d = ST_HL;
            end
            ST_HL: begin
                acc_d   = acc_sum;
                state_d = ST_LH;
            end
            ST_LH: begin
                acc_d   = acc_sum;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            acc_q   <= 32'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            xh_q    <= '0;
            xl_q    <= '0;
            kh_q    <= '0;
            kl_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
            if (state_q == ST_SPLIT) begin
                xh_q <= xh_d;
                xl_q <= xl_d;
                kh_q <= kh_d;
                kl_q <= kl_d;
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.p         = acc_q;

endmodule

// File: doc/loba2_seq_mult.md
# loba2_seq_mult

Sequential, resource-shared LOBA2 approximate multiplier controller for 16-bit unsigned operands. One 4x4 partial-product multiplier and one shifter-accumulator are time-multiplexed across the three LOBA2 terms (HH, HL, LH). An FSM sequences them behind valid/ready handshakes on input and output. The block is the area-optimised counterpart of the combinational LOBA2 16-bit, 4-bit-segment multiplier and produces bit-identical results.

## Interface
- `W`, 16: operand width; fixed at 16 for this block.
- `S`, 4: segment width; fixed at 4.
- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: synchronous reset, active-high.
- `A` input 16: operand A, sampled on input handshake.
- `B` input 16: operand B, sampled on input handshake.
- `IN_VALID` input 1: operands valid.
- `IN_READY` output 1: block can accept operands; high only in IDLE.
- `P` output 32: approximate product; held stable while `OUT_VALID` is high.
- `OUT_VALID` output 1: `P` valid.
- `OUT_READY` input 1: consumer accepts `P`.
- `BUSY` output 1: high in every state except IDLE.

## Operation
- Split rule, applied to each operand X:
  - `kh = max(msb_index(X), 3)`, `Xh = X >> (kh-3)`.
  - `R = X - (Xh << (kh-3))`.
  - `kl = max(msb_index(R), 3)`, `Xl = R >> (kl-3)`; `Xl = 0` when `R == 0`.
  - X < 16 gives an exact split: `Xh = X`, `kh = 3`, `Xl = 0`.
- Product: `P = (Ah*Bh << (kah+kbh-6)) + (Ah*Bl << (kah+kbl-6)) + (Al*Bh << (kal+kbh-6))`.
  - All shift amounts are ≥ 0 under the rule above.
  - Arithmetic is 32-bit with no overflow possible, since each term underestimates and the sum is ≤ A*B.
- States and transitions:
  - IDLE: on `IN_VALID && IN_READY`, register A and B, clear the accumulator, go to SPLIT.
  - SPLIT: compute and register Ah, Al, kah, kal, Bh, Bl, kbh, kbl. If the registered A == 0 or B == 0, go to DONE with accumulator 0. Otherwise go to MUL_HH.
  - MUL_HH: accumulator += Ah*Bh shifted; go to MUL_HL.
  - MUL_HL: accumulator += Ah*Bl shifted; go to MUL_LH.
  - MUL_LH: accumulator += Al*Bh shifted; go to DONE.
  - DONE: `OUT_VALID = 1`, `P` = accumulator. On `OUT_READY`, go to IDLE.
- Only one multiplier instance and one accumulator adder are allowed. The term in use is selected by state.
- `A`/`B` changes outside the accept edge have no effect.

## Timing
- Reset values: state = IDLE, `IN_READY = 1`, `OUT_VALID = 0`, `BUSY = 0`, `P = 0`, accumulator = 0, all split registers = 0.
- Latency: if operands are accepted on edge 0, `OUT_VALID` rises after edge 4. The zero-operand shortcut rises after edge 1.
- Throughput: one result per 6 cycles with `OUT_READY` tied high; 3 cycles for the zero shortcut.
- Backpressure: DONE is held indefinitely while `OUT_READY = 0`.
  - `P` and `OUT_VALID` stay stable; `IN_READY` stays 0.
- `IN_READY` returns to 1 in the cycle after the output handshake edge. There is no same-cycle output-to-input bypass.
- `RST` in any state takes priority over all transitions. The next cycle is IDLE with the reset values, and the in-flight result is discarded.
- `IN_VALID` is ignored while `IN_READY = 0`.

## Test plan
- A=16'h000C, B=16'h000A, `OUT_READY` = 1 → `OUT_VALID` 4 cycles after accept; P=32'h00000078 (exact); BUSY high for SPLIT..DONE.
- A=B=16'hFFFF → P=32'hFD200000, matching the combinational LOBA2 model.
- A=16'h1234, B=16'h5678 → P=32'h061C4000. Then hold `OUT_READY` = 0 for 10 cycles → P stable, `IN_READY` = 0; release → IDLE next cycle.
- A=16'h0000, B=16'h1234 → `OUT_VALID` after 2 edges; P=0. Back-to-back A=16'h0100, B=16'h0003 → P=32'h00000300.
- Assert `RST` during MUL_HL → next cycle IDLE, `OUT_VALID` = 0, `P` = 0, `IN_READY` = 1. A new operation then completes correctly.
- 10k random operand pairs with random `IN_VALID`/`OUT_READY` gaps → every P equals the combinational LOBA2 reference. No lost or duplicated transactions.
